// File: rtl/pbkdf2_iter.sv
// PBKDF2 iteration controller: drives an external HMAC stage C times and
// XOR-accumulates the results into the derived key T = U1 ^ U2 ^ ... ^ UC.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   pass_i, salt_i, iter_i  job inputs (password/key, salt, count C)
//   v_i / r_o               job handshake from upstream
//   dk_o, v_o / r_i         derived key handshake to downstream
//   hmac_prf_o, hmac_salt_o HMAC request message and key
//   hmac_v_o / hmac_r_i     HMAC request handshake
//   hmac_prf_i              HMAC result U
//   hmac_v_i / hmac_r_o     HMAC result handshake
module pbkdf2_iter #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [255:0]      pass_i,
    input  logic [255:0]      salt_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              v_o,
    input  logic              r_i,
    output logic [255:0]      hmac_prf_o,
    output logic [255:0]      hmac_salt_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [255:0]      acc_q, acc_d;
    logic [255:0]      msg_q, msg_d;
    logic [255:0]      pass_q, pass_d;
    logic [255:0]      dk_q, dk_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        acc_d   = acc_q;
        msg_d   = msg_q;
        pass_d  = pass_q;
        dk_d    = dk_q;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    pass_d  = pass_i;
                    // A count of zero still runs one iteration.
                    iter_d  = (iter_i == '0) ? ITER_W'(1) : iter_i;
                    acc_d   = '0;
                    msg_d   = {salt_i[255:32], 32'h0000_0001};
                    cnt_d   = ITER_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hmac_r_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hmac_v_i) begin
                    acc_d = acc_q ^ hmac_prf_i;
                    msg_d = hmac_prf_i;
                    // Compare before incrementing so C = max never wraps.
                    if (cnt_q >= iter_q) begin
                        dk_d    = acc_q ^ hmac_prf_i;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ITER_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                if (r_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            acc_q   <= '0;
            msg_q   <= '0;
            pass_q  <= '0;
            dk_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            acc_q   <= acc_d;
            msg_q   <= msg_d;
            pass_q  <= pass_d;
            dk_q    <= dk_d;
        end
    end

    assign r_o         = (state_q == IDLE);
    assign hmac_v_o    = (state_q == ISSUE);
    assign hmac_r_o    = (state_q == WAIT);
    assign v_o         = (state_q == DONE);
    assign hmac_prf_o  = msg_q;
    assign hmac_salt_o = pass_q;
    assign dk_o        = dk_q;

endmodule

// File: tb/tb_pbkdf2_iter.sv
// Directed testbench for pbkdf2_iter; the bench plays both the
// upstream/downstream and the HMAC stage.
module tb_pbkdf2_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] pass_i, salt_i;
    logic [31:0]  iter_i;
    logic         v_i, r_o, v_o, r_i;
    logic [255:0] dk_o, hmac_prf_o, hmac_salt_o, hmac_prf_i;
    logic         hmac_v_o, hmac_r_i, hmac_v_i, hmac_r_o;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] P1 = {8{32'h1111_2222}};
    localparam logic [255:0] S1 = {8{32'hCAFE_BABE}};
    localparam logic [255:0] P2 = {8{32'h3333_4444}};
    localparam logic [255:0] S2 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] UA = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] UB = {8{32'h0F0F_0F0F}};
    localparam logic [255:0] UC = {8{32'h1234_5678}};
    localparam logic [255:0] UJ = {8{32'hBAD0_BAD0}};

    pbkdf2_iter #(.ITER_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .pass_i(pass_i), .salt_i(salt_i), .iter_i(iter_i),
        .v_i(v_i), .r_o(r_o),
        .dk_o(dk_o), .v_o(v_o), .r_i(r_i),
        .hmac_prf_o(hmac_prf_o), .hmac_salt_o(hmac_salt_o),
        .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i),
        .hmac_prf_i(hmac_prf_i), .hmac_v_i(hmac_v_i),
        .hmac_r_o(hmac_r_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [255:0] p, input logic [255:0] s,
                          input logic [31:0] c);
        pass_i = p; salt_i = s; iter_i = c; v_i = 1'b1;
        tick;
        v_i = 1'b0;
    endtask

    // Act as the HMAC stage for one request: wait for it, capture it,
    // accept it, then return resp in the following cycle.
    task automatic serve(input logic [255:0] resp, output logic [255:0] msg,
                         output logic [255:0] key, output bit ok);
        int n = 0;
        while (!hmac_v_o && n < 50) begin
            tick; n++;
        end
        ok  = hmac_v_o;
        msg = hmac_prf_o;
        key = hmac_salt_o;
        hmac_r_i = 1'b1;
        tick;
        hmac_r_i = 1'b0;
        hmac_prf_i = resp; hmac_v_i = 1'b1;
        tick;
        hmac_v_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        tick;
        checks++;
        if (r_o !== 1'b1 || v_o !== 1'b0 || hmac_v_o !== 1'b0 ||
            hmac_r_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: r_o=%b v_o=%b hv=%b hr=%b, need 1000",
                     r_o, v_o, hmac_v_o, hmac_r_o);
        end
        checks++;
        if (hmac_prf_o !== '0 || hmac_salt_o !== '0 || dk_o !== '0) begin
            errors++;
            $display("FAIL reset_data: prf=%h salt=%h dk=%h, need 0",
                     hmac_prf_o, hmac_salt_o, dk_o);
        end
    endtask

    task automatic test_c1;
        logic [255:0] m, k; bit ok;
        accept(P1, S1, 32'd1);
        checks++;
        if (r_o !== 1'b0 || hmac_v_o !== 1'b1) begin
            errors++;
            $display("FAIL c1_issue: r_o=%b hv=%b, need 0 1", r_o, hmac_v_o);
        end
        serve(UA, m, k, ok);
        checks++;
        if (!ok || m !== {S1[255:32], 32'h1} || k !== P1) begin
            errors++;
            $display("FAIL c1_req: ok=%0d msg=%h key=%h", ok, m, k);
        end
        checks++;
        if (v_o !== 1'b1 || dk_o !== UA) begin
            errors++;
            $display("FAIL c1_dk: v_o=%b dk=%h, need 1 %h", v_o, dk_o, UA);
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
        checks++;
        if (r_o !== 1'b1 || v_o !== 1'b0 || dk_o !== UA) begin
            errors++;
            $display("FAIL c1_idle: r_o=%b v_o=%b dk=%h, need 1 0 %h",
                     r_o, v_o, dk_o, UA);
        end
    endtask

    task automatic test_c3;
        logic [255:0] m1, m2, m3, k1, k2, k3; bit o1, o2, o3;
        accept(P2, S2, 32'd3);
        serve(UA, m1, k1, o1);
        checks++;
        if (v_o !== 1'b0 || hmac_v_o !== 1'b1) begin
            errors++;
            $display("FAIL c3_more: v_o=%b hv=%b, need 0 1", v_o, hmac_v_o);
        end
        serve(UB, m2, k2, o2);
        serve(UC, m3, k3, o3);
        checks++;
        if (!(o1 && o2 && o3) || m1 !== {S2[255:32], 32'h1} ||
            m2 !== UA || m3 !== UB) begin
            errors++;
            $display("FAIL c3_msgs: ok=%0d%0d%0d m1=%h m2=%h m3=%h",
                     o1, o2, o3, m1, m2, m3);
        end
        checks++;
        if (k1 !== P2 || k2 !== P2 || k3 !== P2) begin
            errors++;
            $display("FAIL c3_keys: k1=%h k2=%h k3=%h need %h",
                     k1, k2, k3, P2);
        end
        checks++;
        if (v_o !== 1'b1 || dk_o !== (UA ^ UB ^ UC)) begin
            errors++;
            $display("FAIL c3_dk: v_o=%b dk=%h need %h",
                     v_o, dk_o, UA ^ UB ^ UC);
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
    endtask

    task automatic test_c0;
        logic [255:0] m, k; bit ok;
        accept(P1, S2, 32'd0);
        serve(UC, m, k, ok);
        checks++;
        if (!ok || v_o !== 1'b1 || hmac_v_o !== 1'b0 || dk_o !== UC) begin
            errors++;
            $display("FAIL c0_single: ok=%0d v_o=%b hv=%b dk=%h need %h",
                     ok, v_o, hmac_v_o, dk_o, UC);
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [255:0] m0, k0;
        int dup;
        accept(P2, S1, 32'd1);
        m0 = hmac_prf_o;
        k0 = hmac_salt_o;
        for (int i = 0; i < 4; i++) begin
            // Stray results while not waiting must be ignored.
            hmac_prf_i = UJ; hmac_v_i = 1'b1;
            tick;
            checks++;
            if (hmac_v_o !== 1'b1 || hmac_r_o !== 1'b0 ||
                hmac_prf_o !== m0 || hmac_salt_o !== k0) begin
                errors++;
                $display("FAIL bp_issue%0d: hv=%b hr=%b prf=%h salt=%h",
                         i, hmac_v_o, hmac_r_o, hmac_prf_o, hmac_salt_o);
            end
        end
        hmac_v_i = 1'b0;
        checks++;
        if (m0 !== {S1[255:32], 32'h1} || k0 !== P2) begin
            errors++;
            $display("FAIL bp_req: msg=%h key=%h", m0, k0);
        end
        hmac_r_i = 1'b1;
        tick;
        hmac_r_i = 1'b0;
        hmac_prf_i = UB; hmac_v_i = 1'b1;
        tick;
        hmac_v_i = 1'b0;
        dup = 0;
        for (int i = 0; i < 5; i++) begin
            if (hmac_v_o) dup++;
            checks++;
            if (v_o !== 1'b1 || dk_o !== UB) begin
                errors++;
                $display("FAIL bp_done%0d: v_o=%b dk=%h need %h",
                         i, v_o, dk_o, UB);
            end
            tick;
        end
        checks++;
        if (dup !== 0) begin
            errors++;
            $display("FAIL bp_dup: extra request cycles=%0d need 0", dup);
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [255:0] m, k; bit ok;
        accept(P1, S1, 32'd5);
        serve(UA, m, k, ok);
        hmac_r_i = 1'b1;
        tick;
        hmac_r_i = 1'b0;
        checks++;
        if (hmac_r_o !== 1'b1) begin
            errors++;
            $display("FAIL rm_wait: hr=%b need 1", hmac_r_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (r_o !== 1'b1 || hmac_r_o !== 1'b0 || hmac_v_o !== 1'b0 ||
            v_o !== 1'b0 || hmac_prf_o !== '0 || hmac_salt_o !== '0 ||
            dk_o !== '0) begin
            errors++;
            $display("FAIL rm_async: r=%b hr=%b hv=%b v=%b prf=%h dk=%h",
                     r_o, hmac_r_o, hmac_v_o, v_o, hmac_prf_o, dk_o);
        end
        #1;
        rst = 1'b0;
        hmac_prf_i = UJ; hmac_v_i = 1'b1;
        tick;
        hmac_v_i = 1'b0;
        tick;
        checks++;
        if (r_o !== 1'b1 || v_o !== 1'b0 || hmac_v_o !== 1'b0 ||
            hmac_r_o !== 1'b0 || dk_o !== '0 || hmac_prf_o !== '0 ||
            hmac_salt_o !== '0) begin
            errors++;
            $display("FAIL rm_late: r=%b v=%b hv=%b hr=%b dk=%h prf=%h",
                     r_o, v_o, hmac_v_o, hmac_r_o, dk_o, hmac_prf_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] m1, m2, m3, k1, k2, k3; bit o1, o2, o3;
        pass_i = P1; salt_i = S1; iter_i = 32'd2; v_i = 1'b1;
        tick;
        pass_i = P2; salt_i = S2; iter_i = 32'd1;
        serve(UA, m1, k1, o1);
        serve(UC, m2, k2, o2);
        checks++;
        if (!(o1 && o2) || m1 !== {S1[255:32], 32'h1} || k1 !== P1 ||
            m2 !== UA || k2 !== P1) begin
            errors++;
            $display("FAIL b2b_job1: m1=%h k1=%h m2=%h k2=%h",
                     m1, k1, m2, k2);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (v_o !== 1'b1 || r_o !== 1'b0 || dk_o !== (UA ^ UC)) begin
                errors++;
                $display("FAIL b2b_dk1_%0d: v=%b r=%b dk=%h need %h",
                         i, v_o, r_o, dk_o, UA ^ UC);
            end
            tick;
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
        checks++;
        if (r_o !== 1'b1 || dk_o !== (UA ^ UC)) begin
            errors++;
            $display("FAIL b2b_idle: r=%b dk=%h", r_o, dk_o);
        end
        tick;
        v_i = 1'b0;
        serve(UB, m3, k3, o3);
        checks++;
        if (!o3 || m3 !== {S2[255:32], 32'h1} || k3 !== P2 ||
            v_o !== 1'b1 || dk_o !== UB) begin
            errors++;
            $display("FAIL b2b_job2: m=%h k=%h v=%b dk=%h need %h",
                     m3, k3, v_o, dk_o, UB);
        end
        r_i = 1'b1;
        tick;
        r_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pass_i = '0; salt_i = '0; iter_i = '0; v_i = 1'b0; r_i = 1'b0;
        hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
        test_reset;
        test_c1;
        test_c3;
        test_c0;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
